// File: rtl/pump_dose_driver.sv
// pump_dose_driver
//   Turns the interval timer's active-low motor request into a safe motor drive:
//   two-flop request synchroniser, 16-step PWM soft-start ramp, maximum on-time
//   fault, minimum off-time lockout, and a two-digit BCD count of completed doses.
//
// Ports
//   CLOCK_50   in   50 MHz clock, rising edge
//   reset      in   synchronous reset, active-low
//   req_n      in   asynchronous run request, active-low
//   enable     in   master enable switch, level-sensitive
//   motor      out  registered PWM motor drive, active-high
//   running    out  high while ramping or running
//   fault      out  high while latched in the on-time fault state
//   dose_ones  out  BCD ones digit of completed doses
//   dose_tens  out  BCD tens digit of completed doses
module pump_dose_driver #(
    parameter int unsigned RAMP_STEP_CYCLES = 50000,
    parameter int unsigned MAX_ON_CYCLES    = 150000000,
    parameter int unsigned MIN_OFF_CYCLES   = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req_n,
    input  logic       enable,
    output logic       motor,
    output logic       running,
    output logic       fault,
    output logic [3:0] dose_ones,
    output logic [3:0] dose_tens
);

    localparam logic [27:0] STEP_LAST = 28'(RAMP_STEP_CYCLES - 1);
    localparam logic [27:0] ON_LAST   = 28'(MAX_ON_CYCLES - 1);
    localparam logic [27:0] OFF_LAST  = 28'(MIN_OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_RUN,
        ST_COOLDOWN,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [3:0]  pwm_cnt_q;
    logic [4:0]  duty_q, duty_d;
    logic [27:0] step_cnt_q, step_cnt_d;
    logic [27:0] on_cnt_q, on_cnt_d;
    logic [27:0] off_cnt_q, off_cnt_d;
    logic        motor_q, motor_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic        req;
    logic        active;
    logic        dose_inc;

    assign req    = !sync2_q;
    assign active = (state_q == ST_RAMP) || (state_q == ST_RUN);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            step_cnt_q <= '0;
            on_cnt_q   <= '0;
            off_cnt_q  <= '0;
            motor_q    <= 1'b0;
            ones_q     <= '0;
            tens_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= req_n;
            sync2_q    <= sync1_q;
            pwm_cnt_q  <= pwm_cnt_q + 4'd1;
            duty_q     <= duty_d;
            step_cnt_q <= step_cnt_d;
            on_cnt_q   <= on_cnt_d;
            off_cnt_q  <= off_cnt_d;
            motor_q    <= motor_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        step_cnt_d = step_cnt_q;
        on_cnt_d   = on_cnt_q;
        // Held at zero outside COOLDOWN so every entry starts a fresh lockout.
        off_cnt_d  = '0;
        dose_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                duty_d = '0;
                if (req && enable) begin
                    state_d    = ST_RAMP;
                    on_cnt_d   = '0;
                    step_cnt_d = '0;
                end
            end
            ST_RAMP, ST_RUN: begin
                on_cnt_d = on_cnt_q + 28'd1;
                // Exit priority: on-time fault, then enable loss, then release.
                if ((on_cnt_q == ON_LAST) && req) begin
                    state_d = ST_FAULT;
                    duty_d  = '0;
                end else if (!enable) begin
                    state_d = ST_COOLDOWN;
                    duty_d  = '0;
                end else if (!req) begin
                    state_d  = ST_COOLDOWN;
                    duty_d   = '0;
                    dose_inc = (state_q == ST_RUN);
                end else if (state_q == ST_RAMP) begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = '0;
                        duty_d     = duty_q + 5'd1;
                        if (duty_q == 5'd15) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 28'd1;
                    end
                end
            end
            ST_COOLDOWN: begin
                duty_d = '0;
                if (off_cnt_q == OFF_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    off_cnt_d = off_cnt_q + 28'd1;
                end
            end
            ST_FAULT: begin
                duty_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                duty_d  = '0;
            end
        endcase
    end

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (dose_inc) begin
            if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // duty of 16 exceeds every pwm_cnt value, giving a constant-high drive.
    assign motor_d = active && ({1'b0, pwm_cnt_q} < duty_q);

    assign motor     = motor_q;
    assign running   = active;
    assign fault     = (state_q == ST_FAULT);
    assign dose_ones = ones_q;
    assign dose_tens = tens_q;

endmodule

// File: tb/tb_pump_dose_driver.sv
module tb_pump_dose_driver;

    localparam int N   = 4;
    localparam int MAX = 200;
    localparam int MIN = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_n = 1'b1;
    logic       en = 1'b1;
    logic       motor, running, fault;
    logic [3:0] dose_ones, dose_tens;

    int checks = 0;
    int failures = 0;

    pump_dose_driver #(
        .RAMP_STEP_CYCLES(N),
        .MAX_ON_CYCLES(MAX),
        .MIN_OFF_CYCLES(MIN)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst_n),
        .req_n(req_n),
        .enable(en),
        .motor(motor),
        .running(running),
        .fault(fault),
        .dose_ones(dose_ones),
        .dose_tens(dose_tens)
    );

    always #5 clk = ~clk;

    // Timestamp reference model: mode 0 idle, 1 active (ramp or run), 2 cooldown, 3 fault.
    // Duty and run/ramp are derived from cycles elapsed since activation.
    int n = 0;
    int m_mode = 0;
    int t_ent = 0;
    int n_rst = 0;
    int m_dose = 0;
    bit m_motor = 1'b0;
    bit h1 = 1'b1;
    bit h2 = 1'b1;

    task automatic model_step();
        bit req;
        int el, pwm, duty;
        if (!rst_n) begin
            m_mode = 0; m_dose = 0; m_motor = 1'b0;
            h1 = 1'b1; h2 = 1'b1; n_rst = n;
        end else begin
            req  = !h2;
            el   = n - 1 - t_ent;
            pwm  = (n - 1 - n_rst) % 16;
            duty = (m_mode == 1) ? ((el / N > 16) ? 16 : el / N) : 0;
            m_motor = (m_mode == 1) && (pwm < duty);
            case (m_mode)
                0: if (req && en) begin m_mode = 1; t_ent = n; end
                1: begin
                    if (el == MAX - 1 && req) m_mode = 3;
                    else if (!en) begin m_mode = 2; t_ent = n; end
                    else if (!req) begin
                        if (el >= 16 * N) m_dose = (m_dose + 1) % 100;
                        m_mode = 2; t_ent = n;
                    end
                end
                2: if (el == MIN - 1) m_mode = 0;
                default: if (!en) m_mode = 0;
            endcase
            h2 = h1;
            h1 = req_n;
        end
        n++;
    endtask

    task automatic tick();
        int act_dose;
        @(posedge clk);
        model_step();
        #1;
        act_dose = int'(dose_tens) * 10 + int'(dose_ones);
        checks++;
        if (running !== (m_mode == 1) || fault !== (m_mode == 3) || motor !== m_motor ||
            dose_ones !== 4'(m_dose % 10) || dose_tens !== 4'(m_dose / 10)) begin
            failures++;
            $display("FAIL model cyc=%0d: run/flt/mot/dose actual=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                     n, running, fault, motor, act_dose, (m_mode == 1), (m_mode == 3), m_motor, m_dose);
        end
    endtask

    typedef struct {
        bit rst_n;
        bit req_n;
        bit en;
        int ncyc;
        bit exp_run;
        bit exp_flt;
        int exp_mot;   // 2 = not checked
        int exp_dose;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit a, bit b, bit c, int d, bit e, bit f, int g, int h);
        vec_t v;
        v = '{a, b, c, d, e, f, g, h};
        vecs.push_back(v);
    endfunction

    initial begin
        int act_dose;
        // reset, request, ramp to run
        add(0,1,1,  3, 0,0,0,0);
        add(1,1,1,  5, 0,0,0,0);
        add(1,0,1,  2, 0,0,0,0);
        add(1,0,1,  1, 1,0,0,0);
        add(1,0,1, 64, 1,0,2,0);
        add(1,0,1,  1, 1,0,1,0);
        add(1,0,1, 10, 1,0,1,0);
        // release from run: dose counted, cooldown ignores a pulse
        add(1,1,1,  2, 1,0,1,0);
        add(1,1,1,  1, 0,0,1,1);
        add(1,1,1,  1, 0,0,0,1);
        add(1,0,1,  3, 0,0,0,1);
        add(1,1,1, 10, 0,0,0,1);
        add(1,1,1,  6, 0,0,0,1);
        add(1,1,1,  5, 0,0,0,1);
        // aborted ramp at duty 7
        add(1,0,1,  3, 1,0,0,1);
        add(1,0,1, 28, 1,0,2,1);
        add(1,1,1,  2, 1,0,2,1);
        add(1,1,1,  1, 0,0,2,1);
        add(1,1,1, 25, 0,0,0,1);
        // enable dropped in run
        add(1,0,1,  3, 1,0,0,1);
        add(1,0,1, 70, 1,0,1,1);
        add(1,0,0,  1, 0,0,1,1);
        add(1,1,0, 25, 0,0,0,1);
        // on-time fault
        add(1,0,1,  3, 1,0,0,1);
        add(1,0,1,199, 1,0,1,1);
        add(1,0,1,  1, 0,1,2,1);
        add(1,1,1, 10, 0,1,0,1);
        add(1,1,0,  1, 0,0,0,1);
        add(1,1,1,  3, 0,0,0,1);
        // reset mid-ramp
        add(1,0,1,  3, 1,0,0,1);
        add(1,0,1, 20, 1,0,2,1);
        add(0,0,1,  1, 0,0,0,0);
        add(1,1,1,  5, 0,0,0,0);
        // reset mid-fault
        add(1,0,1,  3, 1,0,0,0);
        add(1,0,1,200, 0,1,2,0);
        add(0,0,1,  1, 0,0,0,0);
        add(1,1,1,  5, 0,0,0,0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            req_n = vecs[i].req_n;
            en    = vecs[i].en;
            repeat (vecs[i].ncyc) tick();
            act_dose = int'(dose_tens) * 10 + int'(dose_ones);
            checks++;
            if (running !== vecs[i].exp_run || fault !== vecs[i].exp_flt ||
                (vecs[i].exp_mot != 2 && motor !== vecs[i].exp_mot[0]) ||
                act_dose != vecs[i].exp_dose) begin
                failures++;
                $display("FAIL vec%0d: run/flt/mot/dose actual=%b/%b/%b/%0d required=%b/%b/%0d/%0d",
                         i, running, fault, motor, act_dose, vecs[i].exp_run,
                         vecs[i].exp_flt, vecs[i].exp_mot, vecs[i].exp_dose);
            end
        end

        // 100 complete doses: BCD carry 09->10 and wrap 99->00
        en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            req_n = 1'b0;
            repeat (70) tick();
            req_n = 1'b1;
            repeat (25) tick();
            checks++;
            if (dose_ones !== 4'((i % 100) % 10) || dose_tens !== 4'((i % 100) / 10)) begin
                failures++;
                $display("FAIL dose_count i=%0d: actual=%0d%0d required=%0d",
                         i, dose_tens, dose_ones, i % 100);
            end
        end

        // Randomised segments against the reference model
        for (int s = 0; s < 60; s++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            req_n = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 150)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
